// File: rtl/binary_distributor.sv
// Pipelined binary-tree router: one keyed item per cycle steered to out[in_dest]; optional broadcast via BINARY_DISTRIBUTOR_BCAST_EN.
// Latency: number of registered nodes on the item's path (every LV_PER_STAGE-th level from the root; 0 = combinational).
// Backpressure: a blocked target stalls only its own path; illegal dests are accepted, discarded and flagged on drop_err.
module binary_distributor #(
    parameter int TARGET_CNT   = 5,
    parameter int KEY_WIDTH    = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int LV_PER_STAGE = 1,
    parameter int DEST_WIDTH   = $clog2(TARGET_CNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DEST_WIDTH-1:0] in_dest,
    input  logic [KEY_WIDTH-1:0]  in_key,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [TARGET_CNT-1:0] out_vld,
    input  logic [TARGET_CNT-1:0] out_rdy,
    output logic [KEY_WIDTH-1:0]  out_key  [TARGET_CNT-1:0],
    output logic [DATA_WIDTH-1:0] out_data [TARGET_CNT-1:0],
    output logic                  drop_err
);

    localparam int NODE_CNT = TARGET_CNT - 1;
    localparam int MASK_W   = 1 << DEST_WIDTH;
    localparam logic [DEST_WIDTH:0] TGT_LIM = (DEST_WIDTH+1)'(TARGET_CNT);
`ifdef BINARY_DISTRIBUTOR_BCAST_EN
    localparam logic [DEST_WIDTH-1:0] BCAST_DEST = '1;
`endif

    // Bit t set when target t's leaf lies under the left child of node.
    function automatic logic [MASK_W-1:0] left_mask(input int node);
        int k;
        left_mask = '0;
        for (int t = 0; t < TARGET_CNT; t++) begin
            k = t + NODE_CNT;
            while (k > 2*node+1) k = (k-1)/2;
            left_mask[t] = (k == 2*node+1);
        end
    endfunction

    function automatic bit node_is_reg(input int node);
        int lvl;
        lvl = $clog2(node+2) - 1;
        if (LV_PER_STAGE == 0) return 1'b0;
        return (lvl % LV_PER_STAGE) == 0;
    endfunction

    logic legal, bcast, drop_sel, root_vld, drop_err_q;

    always_comb begin
        legal = ({1'b0, in_dest} < TGT_LIM);
        bcast = 1'b0;
`ifdef BINARY_DISTRIBUTOR_BCAST_EN
        bcast = !legal && (in_dest == BCAST_DEST);
`endif
        drop_sel = !legal && !bcast;
        root_vld = in_vld && !rst && !drop_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) drop_err_q <= 1'b0;
        else     drop_err_q <= in_vld && drop_sel;
    end

    assign drop_err = drop_err_q;
    assign in_rdy   = !rst && (drop_sel || g_node[0].rdy);

    for (genvar n = 0; n < NODE_CNT; n++) begin : g_node
        localparam logic [MASK_W-1:0] LMASK = left_mask(n);
        localparam int LC = 2*n + 1;
        localparam int RC = 2*n + 2;

        logic                  p_vld, rdy;
        logic [DEST_WIDTH-1:0] p_dest, c_dest;
        logic [KEY_WIDTH-1:0]  p_key, c_key;
        logic [DATA_WIDTH-1:0] p_data, c_data;
        logic                  c_vld_l, c_vld_r, c_rdy_l, c_rdy_r;

        if (n == 0) begin : g_src
            assign p_vld  = root_vld;
            assign p_dest = in_dest;
            assign p_key  = rst ? '0 : in_key;
            assign p_data = rst ? '0 : in_data;
        end else if (n % 2 == 1) begin : g_src
            assign p_vld  = g_node[(n-1)/2].c_vld_l;
            assign p_dest = g_node[(n-1)/2].c_dest;
            assign p_key  = g_node[(n-1)/2].c_key;
            assign p_data = g_node[(n-1)/2].c_data;
        end else begin : g_src
            assign p_vld  = g_node[(n-1)/2].c_vld_r;
            assign p_dest = g_node[(n-1)/2].c_dest;
            assign p_key  = g_node[(n-1)/2].c_key;
            assign p_data = g_node[(n-1)/2].c_data;
        end

        if (LC < NODE_CNT) begin : g_lrdy
            assign c_rdy_l = g_node[LC].rdy;
        end else begin : g_lrdy
            assign c_rdy_l = out_rdy[LC-NODE_CNT];
        end

        if (RC < NODE_CNT) begin : g_rrdy
            assign c_rdy_r = g_node[RC].rdy;
        end else begin : g_rrdy
            assign c_rdy_r = out_rdy[RC-NODE_CNT];
        end

        if (node_is_reg(n)) begin : g_body
            logic                  vld_q, vld_d, sel_l, leave, load;
            logic [DEST_WIDTH-1:0] dest_q, dest_d;
            logic [KEY_WIDTH-1:0]  key_q, key_d;
            logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef BINARY_DISTRIBUTOR_BCAST_EN
            logic sent_l_q, sent_l_d, sent_r_q, sent_r_d, bc;
`endif

            always_comb begin
                sel_l   = LMASK[dest_q];
                c_vld_l = vld_q && sel_l;
                c_vld_r = vld_q && !sel_l;
                leave   = sel_l ? c_rdy_l : c_rdy_r;
`ifdef BINARY_DISTRIBUTOR_BCAST_EN
                // Broadcast entry is held until each child has taken its copy.
                bc = (dest_q == BCAST_DEST);
                if (bc) begin
                    c_vld_l = vld_q && !sent_l_q;
                    c_vld_r = vld_q && !sent_r_q;
                    leave   = (sent_l_q || c_rdy_l) && (sent_r_q || c_rdy_r);
                end
`endif
                rdy    = !vld_q || leave;
                load   = p_vld && rdy;
                vld_d  = load || (vld_q && !leave);
                dest_d = load ? p_dest : dest_q;
                key_d  = load ? p_key  : key_q;
                data_d = load ? p_data : data_q;
`ifdef BINARY_DISTRIBUTOR_BCAST_EN
                sent_l_d = !(load || leave) && (sent_l_q || (c_vld_l && c_rdy_l));
                sent_r_d = !(load || leave) && (sent_r_q || (c_vld_r && c_rdy_r));
`endif
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    dest_q <= '0;
                    key_q  <= '0;
                    data_q <= '0;
`ifdef BINARY_DISTRIBUTOR_BCAST_EN
                    sent_l_q <= 1'b0;
                    sent_r_q <= 1'b0;
`endif
                end else begin
                    vld_q  <= vld_d;
                    dest_q <= dest_d;
                    key_q  <= key_d;
                    data_q <= data_d;
`ifdef BINARY_DISTRIBUTOR_BCAST_EN
                    sent_l_q <= sent_l_d;
                    sent_r_q <= sent_r_d;
`endif
                end
            end

            assign c_dest = dest_q;
            assign c_key  = key_q;
            assign c_data = data_q;
        end else begin : g_body
            logic sel_l;

            always_comb begin
                sel_l   = LMASK[p_dest];
                c_vld_l = p_vld && sel_l;
                c_vld_r = p_vld && !sel_l;
                rdy     = sel_l ? c_rdy_l : c_rdy_r;
`ifdef BINARY_DISTRIBUTOR_BCAST_EN
                // Without storage a fork must hand off to both children in the same cycle.
                if (p_dest == BCAST_DEST) begin
                    c_vld_l = p_vld && c_rdy_r;
                    c_vld_r = p_vld && c_rdy_l;
                    rdy     = c_rdy_l && c_rdy_r;
                end
`endif
            end

            assign c_dest = p_dest;
            assign c_key  = p_key;
            assign c_data = p_data;
        end
    end

    for (genvar t = 0; t < TARGET_CNT; t++) begin : g_tgt
        localparam int K = t + NODE_CNT;
        localparam int P = (K-1)/2;
        logic unused_dest;

        if (K % 2 == 1) begin : g_side
            assign out_vld[t] = g_node[P].c_vld_l;
        end else begin : g_side
            assign out_vld[t] = g_node[P].c_vld_r;
        end
        assign out_key[t]  = g_node[P].c_key;
        assign out_data[t] = g_node[P].c_data;
        assign unused_dest = ^g_node[P].c_dest;
    end

endmodule

// File: tb/tb_binary_distributor.sv
// Directed bench for binary_distributor (TARGET_CNT=5, LV_PER_STAGE=1): latency, streaming, blocking, drop, reset, broadcast.
module tb_binary_distributor;

    localparam int TC = 5;
    localparam int KW = 6;
    localparam int DW = 16;
    localparam int DESTW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_vld;
    logic             in_rdy;
    logic [DESTW-1:0] in_dest;
    logic [KW-1:0]    in_key;
    logic [DW-1:0]    in_data;
    logic [TC-1:0]    out_vld;
    logic [TC-1:0]    out_rdy;
    logic [KW-1:0]    out_key  [TC-1:0];
    logic [DW-1:0]    out_data [TC-1:0];
    logic             drop_err;

    int checks = 0;
    int errors = 0;

    logic [TC-1:0] exp_b2b [9] = '{5'b00000, 5'b00000, 5'b00001, 5'b00010, 5'b00100,
                                   5'b00000, 5'b01000, 5'b10000, 5'b00000};

    binary_distributor dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_dest  (in_dest),
        .in_key   (in_key),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_key  (out_key),
        .out_data (out_data),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input int k, input int dat);
        in_vld  = 1'b1;
        in_dest = DESTW'(d);
        in_key  = KW'(k);
        in_data = DW'(dat);
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_dest = '0; in_key = '0; in_data = '0; out_rdy = '1;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_key0", out_key[0], 0);
        chk("rst_data4", out_data[4], 0);

        // latency: dest0 (depth 2) then dest3 (depth 3)
        @(negedge clk); rst = 1'b0; drive(0, 'h11, 'h1111); #1;
        chk("lat_in_rdy", in_rdy, 1);
        @(negedge clk); drive(3, 'h22, 'h2222); #1;
        chk("lat_c1_vld", out_vld, 0);
        @(negedge clk); in_vld = 1'b0; #1;
        chk("lat_c2_vld", out_vld, 5'b00001);
        chk("lat_c2_key0", out_key[0], 'h11);
        chk("lat_c2_data0", out_data[0], 'h1111);
        @(negedge clk); #1;
        chk("lat_c3_vld", out_vld, 0);
        @(negedge clk); #1;
        chk("lat_c4_vld", out_vld, 5'b01000);
        chk("lat_c4_key3", out_key[3], 'h22);
        @(negedge clk); #1;
        chk("lat_c5_vld", out_vld, 0);

        // back-to-back to every target
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 5) drive(c, 'h30 + c, 'hA000 + c);
            else in_vld = 1'b0;
            #1;
            if (c < 5) chk("b2b_in_rdy", in_rdy, 1);
            chk("b2b_vld", out_vld, exp_b2b[c]);
            for (int t = 0; t < TC; t++) begin
                if (exp_b2b[c][t]) begin
                    chk("b2b_data", out_data[t], 'hA000 + t);
                    chk("b2b_key", out_key[t], 'h30 + t);
                end
            end
        end

        // target 3 blocked: dest1 bypasses, then nodes 3,1,0 fill
        @(negedge clk); out_rdy = 5'b10111; drive(3, 'h21, 'hB001); #1;
        chk("blk0_in_rdy", in_rdy, 1);
        @(negedge clk); drive(1, 'h22, 'hB002); #1;
        chk("blk1_in_rdy", in_rdy, 1);
        @(negedge clk); drive(3, 'h23, 'hB003); #1;
        chk("blk2_in_rdy", in_rdy, 1);
        chk("blk2_vld", out_vld, 0);
        @(negedge clk); drive(4, 'h24, 'hB004); #1;
        chk("blk3_in_rdy", in_rdy, 1);
        chk("blk3_vld", out_vld, 5'b01010);
        chk("blk3_key1", out_key[1], 'h22);
        chk("blk3_data1", out_data[1], 'hB002);
        chk("blk3_key3", out_key[3], 'h21);
        @(negedge clk); drive(3, 'h25, 'hB005); #1;
        chk("blk4_in_rdy", in_rdy, 0);
        chk("blk4_vld", out_vld, 5'b01000);
        @(negedge clk); #1;
        chk("blk5_in_rdy", in_rdy, 0);
        chk("blk5_key3", out_key[3], 'h21);
        @(negedge clk); out_rdy = '1; #1;
        chk("blk6_in_rdy", in_rdy, 1);
        chk("blk6_vld", out_vld, 5'b01000);
        chk("blk6_key3", out_key[3], 'h21);
        @(negedge clk); in_vld = 1'b0; #1;
        chk("blk7_vld", out_vld, 5'b01000);
        chk("blk7_key3", out_key[3], 'h23);
        @(negedge clk); #1;
        chk("blk8_vld", out_vld, 5'b10000);
        chk("blk8_key4", out_key[4], 'h24);
        chk("blk8_data4", out_data[4], 'hB004);
        @(negedge clk); #1;
        chk("blk9_vld", out_vld, 5'b01000);
        chk("blk9_key3", out_key[3], 'h25);
        @(negedge clk); #1;
        chk("blk10_vld", out_vld, 0);

        // illegal dest 6
        @(negedge clk); drive(6, 'h3F, 'hDEAD); #1;
        chk("drop_in_rdy", in_rdy, 1);
        chk("drop_d0_err", drop_err, 0);
        @(negedge clk); in_vld = 1'b0; #1;
        chk("drop_d1_err", drop_err, 1);
        chk("drop_d1_vld", out_vld, 0);
        @(negedge clk); #1;
        chk("drop_d2_err", drop_err, 0);
        chk("drop_d2_vld", out_vld, 0);

`ifdef BINARY_DISTRIBUTOR_BCAST_EN
        // broadcast with target 2 stalled
        @(negedge clk); out_rdy = 5'b11011; drive(7, 'h15, 'hBEEF); #1;
        chk("bc0_in_rdy", in_rdy, 1);
        @(negedge clk); in_vld = 1'b0; #1;
        chk("bc1_vld", out_vld, 0);
        chk("bc1_drop", drop_err, 0);
        @(negedge clk); #1;
        chk("bc2_vld", out_vld, 5'b00111);
        chk("bc2_data0", out_data[0], 'hBEEF);
        chk("bc2_data1", out_data[1], 'hBEEF);
        @(negedge clk); #1;
        chk("bc3_vld", out_vld, 5'b11100);
        chk("bc3_data3", out_data[3], 'hBEEF);
        chk("bc3_data4", out_data[4], 'hBEEF);
        @(negedge clk); #1;
        chk("bc4_vld", out_vld, 5'b00100);
        @(negedge clk); out_rdy = '1; #1;
        chk("bc5_vld", out_vld, 5'b00100);
        chk("bc5_data2", out_data[2], 'hBEEF);
        @(negedge clk); #1;
        chk("bc6_vld", out_vld, 0);
`else
        // all-ones dest is just another illegal target
        @(negedge clk); drive(7, 'h15, 'hBEEF); #1;
        chk("drop7_in_rdy", in_rdy, 1);
        @(negedge clk); in_vld = 1'b0; #1;
        chk("drop7_err", drop_err, 1);
        chk("drop7_vld", out_vld, 0);
        @(negedge clk); #1;
        chk("drop7_err_clr", drop_err, 0);
`endif

        // reset with items in flight
        @(negedge clk); drive(3, 'h31, 'hC001);
        @(negedge clk); drive(4, 'h32, 'hC002);
        @(negedge clk); drive(0, 'h33, 'hC003);
        @(negedge clk); in_vld = 1'b0; rst = 1'b1; #1;
        chk("rstf_r3_in_rdy", in_rdy, 0);
        @(negedge clk); #1;
        chk("rstf_vld", out_vld, 0);
        chk("rstf_in_rdy", in_rdy, 0);
        chk("rstf_key0", out_key[0], 0);
        chk("rstf_key3", out_key[3], 0);
        chk("rstf_key4", out_key[4], 0);
        chk("rstf_data3", out_data[3], 0);
        chk("rstf_drop", drop_err, 0);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("rstf_stale_vld", out_vld, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
